cpu_control_fsm: RTL
====================

Name: cpu_control_fsm

Overview:
- Multi-cycle sequencer for the 33-bit CPU datapath.
- Owns the PC and the instruction register (IR), and splits the IR into fields through the existing decode_instruction module.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives register-file, ALU, data-memory and PC controls.
- Sits between instruction memory, data memory and the regfile/ALU datapath.

Parameters:
- INSTRUCTION_WIDTH, 33, instruction word width (params.v)
- WIDTH_OPCODE, 5, opcode field width (params.v)
- REGFILE_ADDR_BITS, 4, register address width (params.v)
- IMMEDIATE_WIDTH, 16, immediate field width (params.v)
- PC_WIDTH, 16, program counter / instruction address width

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- run  in  1  permits leaving IDLE; sampled only in IDLE
- imem_addr  out  PC_WIDTH  instruction fetch address (= pc)
- imem_req  out  1  fetch request
- imem_ready  in  1  instruction valid this cycle
- imem_data  in  INSTRUCTION_WIDTH  fetched instruction
- rf_raddr1  out  REGFILE_ADDR_BITS  read port 1 (reg_dest field, so branch/SR base reads work)
- rf_raddr2  out  REGFILE_ADDR_BITS  read port 2 (reg_source_1, or reg_source_2 for 3-register ALU ops)
- rf_waddr  out  REGFILE_ADDR_BITS  write address
- rf_we  out  1  register write strobe
- wb_sel  out  2  writeback source: 0 ALU, 1 memory, 2 immediate, 3 rf_raddr2 data (MOVE)
- alu_op  out  4  ALU operation code
- alu_src_imm  out  1  ALU B operand = sign-extended immediate
- alu_zero  in  1  ALU result == 0
- alu_neg  in  1  ALU result MSB
- imm_out  out  IMMEDIATE_WIDTH  IR immediate field
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write (SR)
- dmem_ready  in  1  data memory done
- flag_z  out  1  CMP zero flag
- flag_n  out  1  CMP negative flag
- halted  out  1  trap state reached
- retired  out  16  retired-instruction counter

Behaviour:
- Reset values (asynchronous): state=IDLE, pc=0, IR=0, retired=0, flags=0. All strobes (imem_req, rf_we, dmem_req, dmem_we) =0. halted=0.
- Opcode encoding:
  - NOP0, LR1, LI2, SR3, MOVE4, ADD5, ADDI6, SUB7, CMP8
  - AND9, OR10, NOT11, SHL12, SHR13, BNE14, BE15
  - Opcodes 16..31 are illegal.
- IDLE: when run=1, go to FETCH next cycle.
- FETCH: imem_req=1, imem_addr=pc. Hold until imem_ready=1; then IR<=imem_data and go to DECODE. A wait of any length is legal.
- DECODE (1 cycle): drive read addresses from IR.
  - Illegal opcode -> TRAP.
  - NOP -> pc+1, retire, FETCH.
  - All other opcodes -> EXEC.
- EXEC (1 cycle): alu_op and alu_src_imm valid.
  - LR, SR: address = rf(reg_dest or reg_source_1) + sext(imm); go to MEM.
  - CMP: flag_z<=alu_zero, flag_n<=alu_neg; pc+1, retire, FETCH.
  - BE/BNE: ALU computes reg_dest − reg_source_1. If taken (zero / not zero), pc<=pc+1+sext(imm), else pc+1; retire, FETCH.
  - LI, MOVE, arithmetic/logic/shift ops: go to WB.
- MEM: dmem_req=1, dmem_we=(opcode==SR). Hold until dmem_ready.
  - LR -> WB.
  - SR -> pc+1, retire, FETCH.
- WB (1 cycle): rf_waddr=reg_dest, wb_sel per opcode. rf_we=1 unless reg_dest==0 (R0 stays zero). Then pc+1, retire, FETCH.
- TRAP: halted=1, all strobes 0. Exit only by reset.
- PC arithmetic is modulo 2^PC_WIDTH. The branch offset is sign-extended to PC_WIDTH; wrap-around is silent.
- retired increments by exactly 1 per completed instruction and wraps from 0xFFFF to 0.
- run is ignored outside IDLE.
- Reset mid-MEM or mid-FETCH: strobes drop asynchronously; no write is issued afterwards.
- Exactly one of imem_req and dmem_req may be high in any cycle.
- Cycle counts with zero-wait memories (ready in the first request cycle):
  - NOP 2 cycles; CMP and branch 3; ALU ops/LI/MOVE 4; SR 4; LR 5.

Decomposition:
- Package/params.v additions:
  - opcode localparams INSTR_* (values above)
  - state encodings
  - ALU_OP_* codes
  - WB_SEL_* codes
  - PC_WIDTH
- Instantiates decode_instruction on the IR.
- One combinational sub-module, ctrl_decode: maps opcode to alu_op, alu_src_imm, wb_sel, needs_mem, needs_wb, is_branch, illegal. The FSM consumes these fields.

Test Plan:
- Program 0x021000000, 0x022000000, 0x02300000A, 0x052210000, 0x061100001, 0x0E130FFFD at pc 0..5, zero-wait memory.
  - Required: loop exits when R1==R3; add and addi run 10 times each; final R1=0x0A, R2=0x2D.
  - Required: pc=6 after exit; retired=3+3×10=33.
- LR R1,R0[0x10] with dmem_ready delayed 3 cycles -> dmem_req held 4 cycles; rf_we pulses once with waddr=1, wb_sel=1; the instruction takes 8 cycles total.
- Opcode 0x1F fetched -> halted=1 two cycles after imem_ready; no further imem_req; only reset clears it.
- LI R0,0x55 -> rf_we stays 0 through WB; retired increments.
- CMP R1,R2 with R1=5, R2=7 -> flag_z=0, flag_n=1; pc+1.
- Reset asserted during MEM of an SR -> dmem_req and dmem_we drop the same cycle; after release, pc=0, state IDLE, halted=0.

Source files
------------

// File: rtl/cpu_control_fsm_pkg.sv
// Shared widths, opcode values, FSM states and control-field encodings for the
// multi-cycle CPU sequencer.
package cpu_control_fsm_pkg;
  localparam int INSTRUCTION_WIDTH = 33;
  localparam int WIDTH_OPCODE      = 5;
  localparam int REGFILE_ADDR_BITS = 4;
  localparam int IMMEDIATE_WIDTH   = 16;
  localparam int PC_WIDTH          = 16;

  localparam logic [WIDTH_OPCODE-1:0] INSTR_NOP  = 5'd0;
  localparam logic [WIDTH_OPCODE-1:0] INSTR_LR   = 5'd1;
  localparam logic [WIDTH_OPCODE-1:0] INSTR_LI   = 5'd2;
  localparam logic [WIDTH_OPCODE-1:0] INSTR_SR   = 5'd3;
  localparam logic [WIDTH_OPCODE-1:0] INSTR_MOVE = 5'd4;
  localparam logic [WIDTH_OPCODE-1:0] INSTR_ADD  = 5'd5;
  localparam logic [WIDTH_OPCODE-1:0] INSTR_ADDI = 5'd6;
  localparam logic [WIDTH_OPCODE-1:0] INSTR_SUB  = 5'd7;
  localparam logic [WIDTH_OPCODE-1:0] INSTR_CMP  = 5'd8;
  localparam logic [WIDTH_OPCODE-1:0] INSTR_AND  = 5'd9;
  localparam logic [WIDTH_OPCODE-1:0] INSTR_OR   = 5'd10;
  localparam logic [WIDTH_OPCODE-1:0] INSTR_NOT  = 5'd11;
  localparam logic [WIDTH_OPCODE-1:0] INSTR_SHL  = 5'd12;
  localparam logic [WIDTH_OPCODE-1:0] INSTR_SHR  = 5'd13;
  localparam logic [WIDTH_OPCODE-1:0] INSTR_BNE  = 5'd14;
  localparam logic [WIDTH_OPCODE-1:0] INSTR_BE   = 5'd15;

  localparam logic [3:0] ALU_OP_ADD  = 4'd0;
  localparam logic [3:0] ALU_OP_SUB  = 4'd1;
  localparam logic [3:0] ALU_OP_AND  = 4'd2;
  localparam logic [3:0] ALU_OP_OR   = 4'd3;
  localparam logic [3:0] ALU_OP_NOT  = 4'd4;
  localparam logic [3:0] ALU_OP_SHL  = 4'd5;
  localparam logic [3:0] ALU_OP_SHR  = 4'd6;
  localparam logic [3:0] ALU_OP_PASS = 4'd7;

  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MEM = 2'd1;
  localparam logic [1:0] WB_SEL_IMM = 2'd2;
  localparam logic [1:0] WB_SEL_REG = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_TRAP
  } state_t;
endpackage

// File: rtl/cpu_control_fsm_ctrl_decode.sv
// Opcode -> static control fields consumed by the sequencer FSM.
module ctrl_decode
  import cpu_control_fsm_pkg::*;
(
  input  logic [WIDTH_OPCODE-1:0] i_opcode,
  output logic [3:0]              o_alu_op,
  output logic                    o_alu_src_imm,
  output logic [1:0]              o_wb_sel,
  output logic                    o_use_rs2,
  output logic                    o_needs_mem,
  output logic                    o_needs_wb,
  output logic                    o_is_branch,
  output logic                    o_illegal
);
  always_comb begin
    o_alu_op      = ALU_OP_PASS;
    o_alu_src_imm = 1'b0;
    o_wb_sel      = WB_SEL_ALU;
    o_use_rs2     = 1'b0;
    o_needs_mem   = 1'b0;
    o_needs_wb    = 1'b0;
    o_is_branch   = 1'b0;
    o_illegal     = 1'b0;
    case (i_opcode)
      INSTR_NOP:  ;
      INSTR_LR:   begin o_alu_op = ALU_OP_ADD; o_alu_src_imm = 1'b1; o_needs_mem = 1'b1;
                        o_needs_wb = 1'b1; o_wb_sel = WB_SEL_MEM; end
      INSTR_LI:   begin o_needs_wb = 1'b1; o_wb_sel = WB_SEL_IMM; end
      INSTR_SR:   begin o_alu_op = ALU_OP_ADD; o_alu_src_imm = 1'b1; o_needs_mem = 1'b1; end
      INSTR_MOVE: begin o_needs_wb = 1'b1; o_wb_sel = WB_SEL_REG; end
      INSTR_ADD:  begin o_alu_op = ALU_OP_ADD; o_use_rs2 = 1'b1; o_needs_wb = 1'b1; end
      INSTR_ADDI: begin o_alu_op = ALU_OP_ADD; o_alu_src_imm = 1'b1; o_needs_wb = 1'b1; end
      INSTR_SUB:  begin o_alu_op = ALU_OP_SUB; o_use_rs2 = 1'b1; o_needs_wb = 1'b1; end
      INSTR_CMP:  o_alu_op = ALU_OP_SUB;
      INSTR_AND:  begin o_alu_op = ALU_OP_AND; o_use_rs2 = 1'b1; o_needs_wb = 1'b1; end
      INSTR_OR:   begin o_alu_op = ALU_OP_OR;  o_use_rs2 = 1'b1; o_needs_wb = 1'b1; end
      INSTR_NOT:  begin o_alu_op = ALU_OP_NOT; o_needs_wb = 1'b1; end
      INSTR_SHL:  begin o_alu_op = ALU_OP_SHL; o_use_rs2 = 1'b1; o_needs_wb = 1'b1; end
      INSTR_SHR:  begin o_alu_op = ALU_OP_SHR; o_use_rs2 = 1'b1; o_needs_wb = 1'b1; end
      INSTR_BNE,
      INSTR_BE:   begin o_alu_op = ALU_OP_SUB; o_is_branch = 1'b1; end
      default:    o_illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/decode_instruction.sv
// Splits an instruction word into opcode, three register fields and immediate.
module decode_instruction
  import cpu_control_fsm_pkg::*;
(
  input  logic [INSTRUCTION_WIDTH-1:0] i_instr,
  output logic [WIDTH_OPCODE-1:0]      o_opcode,
  output logic [REGFILE_ADDR_BITS-1:0] o_reg_dest,
  output logic [REGFILE_ADDR_BITS-1:0] o_reg_source_1,
  output logic [REGFILE_ADDR_BITS-1:0] o_reg_source_2,
  output logic [IMMEDIATE_WIDTH-1:0]   o_immediate
);
  assign o_opcode       = i_instr[32:28];
  assign o_reg_dest     = i_instr[27:24];
  assign o_reg_source_1 = i_instr[23:20];
  assign o_reg_source_2 = i_instr[19:16];
  assign o_immediate    = i_instr[15:0];
endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle sequencer: owns PC/IR/flags/retired count and steps each
// instruction through FETCH/DECODE/EXEC/MEM/WB.
module cpu_control_fsm
  import cpu_control_fsm_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         run,
  output logic [PC_WIDTH-1:0]          imem_addr,
  output logic                         imem_req,
  input  logic                         imem_ready,
  input  logic [INSTRUCTION_WIDTH-1:0] imem_data,
  output logic [REGFILE_ADDR_BITS-1:0] rf_raddr1,
  output logic [REGFILE_ADDR_BITS-1:0] rf_raddr2,
  output logic [REGFILE_ADDR_BITS-1:0] rf_waddr,
  output logic                         rf_we,
  output logic [1:0]                   wb_sel,
  output logic [3:0]                   alu_op,
  output logic                         alu_src_imm,
  input  logic                         alu_zero,
  input  logic                         alu_neg,
  output logic [IMMEDIATE_WIDTH-1:0]   imm_out,
  output logic                         dmem_req,
  output logic                         dmem_we,
  input  logic                         dmem_ready,
  output logic                         flag_z,
  output logic                         flag_n,
  output logic                         halted,
  output logic [15:0]                  retired
);
  state_t                         r_state, w_state_nxt;
  logic [PC_WIDTH-1:0]            r_pc;
  logic [INSTRUCTION_WIDTH-1:0]   r_ir;
  logic [15:0]                    r_retired;
  logic                           r_flag_z, r_flag_n;

  logic [WIDTH_OPCODE-1:0]        w_opcode;
  logic [REGFILE_ADDR_BITS-1:0]   w_rd, w_rs1, w_rs2;
  logic [IMMEDIATE_WIDTH-1:0]     w_imm;
  logic                           w_use_rs2, w_needs_mem, w_needs_wb, w_is_branch, w_illegal;
  logic                           w_ir_load, w_finish, w_take, w_flag_load;
  logic [PC_WIDTH-1:0]            w_off;

  decode_instruction u_dec (
    .i_instr(r_ir), .o_opcode(w_opcode), .o_reg_dest(w_rd),
    .o_reg_source_1(w_rs1), .o_reg_source_2(w_rs2), .o_immediate(w_imm)
  );

  ctrl_decode u_ctrl (
    .i_opcode(w_opcode), .o_alu_op(alu_op), .o_alu_src_imm(alu_src_imm),
    .o_wb_sel(wb_sel), .o_use_rs2(w_use_rs2), .o_needs_mem(w_needs_mem),
    .o_needs_wb(w_needs_wb), .o_is_branch(w_is_branch), .o_illegal(w_illegal)
  );

  // Branch offset sign-extended to PC width; PC math wraps silently.
  assign w_off = PC_WIDTH'($signed(w_imm));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_pc      <= '0;
      r_ir      <= '0;
      r_retired <= '0;
      r_flag_z  <= 1'b0;
      r_flag_n  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_ir_load) r_ir <= imem_data;
      if (w_flag_load) begin
        r_flag_z <= alu_zero;
        r_flag_n <= alu_neg;
      end
      if (w_finish) begin
        r_pc      <= w_take ? r_pc + PC_WIDTH'(1) + w_off : r_pc + PC_WIDTH'(1);
        r_retired <= r_retired + 16'd1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ir_load   = 1'b0;
    w_finish    = 1'b0;
    w_take      = 1'b0;
    w_flag_load = 1'b0;
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    rf_we       = 1'b0;
    case (r_state)
      ST_IDLE:   if (run) w_state_nxt = ST_FETCH;
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          w_ir_load   = 1'b1;
          w_state_nxt = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (w_illegal)                 w_state_nxt = ST_TRAP;
        else if (w_opcode == INSTR_NOP) w_finish   = 1'b1;
        else                           w_state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        if (w_needs_mem)      w_state_nxt = ST_MEM;
        else if (w_needs_wb)  w_state_nxt = ST_WB;
        else begin
          w_finish    = 1'b1;
          w_flag_load = (w_opcode == INSTR_CMP);
          w_take      = w_is_branch & ((w_opcode == INSTR_BE) ? alu_zero : ~alu_zero);
        end
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (w_opcode == INSTR_SR);
        if (dmem_ready) begin
          if (w_needs_wb) w_state_nxt = ST_WB;
          else            w_finish    = 1'b1;
        end
      end
      ST_WB: begin
        rf_we    = (w_rd != '0);
        w_finish = 1'b1;
      end
      ST_TRAP:   ;
      default:   w_state_nxt = ST_IDLE;
    endcase
    if (w_finish) w_state_nxt = ST_FETCH;
  end

  assign imem_addr = r_pc;
  assign rf_raddr1 = w_rd;
  assign rf_raddr2 = w_use_rs2 ? w_rs2 : w_rs1;
  assign rf_waddr  = w_rd;
  assign imm_out   = w_imm;
  assign flag_z    = r_flag_z;
  assign flag_n    = r_flag_n;
  assign halted    = (r_state == ST_TRAP);
  assign retired   = r_retired;
endmodule
